// File: rtl/rpsc_pkg.sv
// rtl/rpsc_pkg.sv - shared types and default constants for the RPSC fault annunciator
package rpsc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NEW   = 2'd1,
        ACKED = 2'd2
    } ch_state_t;

    localparam int N_CH_DEF       = 8;
    localparam int DEB_CYC_DEF    = 16;
    localparam int FLASH_HALF_DEF = 25_000_000;

endpackage

// File: rtl/rpsc_fault_annunciator_if.sv
// rtl/rpsc_fault_annunciator_if.sv - panel-side signal bundle of the fault annunciator
interface rpsc_fault_annunciator_if #(
    parameter int N_CH = 8
);
    localparam int FO_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] fault_in;
    logic            ack;
    logic            clr;
    logic            LA_Test;
    logic [N_CH-1:0] fault_latched;
    logic [N_CH-1:0] lamp;
    logic            horn;
    logic            trip_out;
    logic [FO_W-1:0] first_out;
    logic            first_valid;

    modport master (
        output fault_in, ack, clr, LA_Test,
        input  fault_latched, lamp, horn, trip_out, first_out, first_valid
    );

    modport slave (
        input  fault_in, ack, clr, LA_Test,
        output fault_latched, lamp, horn, trip_out, first_out, first_valid
    );
endinterface

// File: rtl/rpsc_debounce.sv
// rtl/rpsc_debounce.sv - 2-FF synchroniser plus stable-count debounce for one fault line
module rpsc_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEB_CYC);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // The counter only advances while the synced level disagrees with the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/rpsc_fault_annunciator.sv
// rtl/rpsc_fault_annunciator.sv - per-channel fault latching, first-out, lamp flash and horn
module rpsc_fault_annunciator
    import rpsc_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int DEB_CYC    = DEB_CYC_DEF,
    parameter int FLASH_HALF = FLASH_HALF_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    rpsc_fault_annunciator_if.slave bus
);
    localparam int FO_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FW   = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    ch_state_t       state     [N_CH];
    ch_state_t       state_nxt [N_CH];
    logic [N_CH-1:0] deb;
    logic [N_CH-1:0] entering;
    logic [N_CH-1:0] latched_nxt;
    logic [N_CH-1:0] lamp_c;
    logic [FO_W-1:0] low_idx;
    logic            all_idle;
    logic            ack_q, clr_q, la_q;
    logic            ack_evt, clr_evt;
    logic [FW-1:0]   flash_cnt;
    logic            phase;
    logic [N_CH-1:0] fault_latched_q;
    logic            trip_q, horn_q, first_valid_q;
    logic [FO_W-1:0] first_out_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_deb
        rpsc_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk   (clk),
            .reset (reset),
            .din   (bus.fault_in[g]),
            .dout  (deb[g])
        );
    end

    assign ack_evt = bus.ack & ~ack_q;
    assign clr_evt = bus.clr & ~clr_q;

    // IDLE->NEW takes priority over everything, so an ack in the entry cycle is lost.
    always_comb begin
        entering    = '0;
        latched_nxt = '0;
        lamp_c      = '0;
        low_idx     = '0;
        all_idle    = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                IDLE: begin
                    if (deb[i]) begin
                        state_nxt[i] = NEW;
                        entering[i]  = 1'b1;
                    end
                end
                NEW:     if (ack_evt) state_nxt[i] = ACKED;
                ACKED:   if (clr_evt && !deb[i]) state_nxt[i] = IDLE;
                default: state_nxt[i] = IDLE;
            endcase
            latched_nxt[i] = (state_nxt[i] != IDLE);
            lamp_c[i]      = la_q | (state[i] == ACKED) | ((state[i] == NEW) & phase);
            if (state[i] != IDLE) all_idle = 1'b0;
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (entering[i]) low_idx = FO_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) state[i] <= IDLE;
            ack_q           <= 1'b0;
            clr_q           <= 1'b0;
            la_q            <= 1'b0;
            flash_cnt       <= '0;
            phase           <= 1'b1;
            fault_latched_q <= '0;
            trip_q          <= 1'b0;
            horn_q          <= 1'b0;
            first_out_q     <= '0;
            first_valid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) state[i] <= state_nxt[i];
            ack_q           <= bus.ack;
            clr_q           <= bus.clr;
            la_q            <= bus.LA_Test;
            fault_latched_q <= latched_nxt;
            trip_q          <= |latched_nxt;
            if (flash_cnt == FW'(FLASH_HALF - 1)) begin
                flash_cnt <= '0;
                phase     <= ~phase;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
            if (|entering)    horn_q <= 1'b1;
            else if (ack_evt) horn_q <= 1'b0;
            if (!first_valid_q && |entering) begin
                first_out_q   <= low_idx;
                first_valid_q <= 1'b1;
            end else if (first_valid_q && all_idle) begin
                first_valid_q <= 1'b0;
            end
        end
    end

    assign bus.fault_latched = fault_latched_q;
    assign bus.lamp          = lamp_c;
    assign bus.horn          = horn_q;
    assign bus.trip_out      = trip_q;
    assign bus.first_out     = first_out_q;
    assign bus.first_valid   = first_valid_q;
endmodule
